// File: rtl/lvds_pkg.sv
// Shared constants for the LVDS panel link: sequencer state encoding,
// default panel timing at the 72 MHz pixel clock, and panel geometry
// used by the timing generator.
package lvds_pkg;

    // Sequencer states; the encoding is visible on the state_o debug port.
    typedef enum logic [3:0] {
        ST_OFF        = 4'd0,
        ST_VDD_UP     = 4'd1,
        ST_VID_ARM    = 4'd2,
        ST_VID_UP     = 4'd3,
        ST_RUN        = 4'd4,
        ST_BL_DOWN    = 4'd5,
        ST_VID_DISARM = 4'd6,
        ST_VID_DOWN   = 4'd7,
        ST_COOL       = 4'd8
    } seq_state_e;

    // Panel datasheet timing, in 72 MHz pixel clocks.
    localparam int unsigned T_VDD_VID_DEF = 32'd1200000;   // T2, ~16.7 ms
    localparam int unsigned T_VID_BL_DEF  = 32'd14400000;  // T3, 200 ms
    localparam int unsigned T_BL_VID_DEF  = 32'd14400000;  // T4, 200 ms
    localparam int unsigned T_VID_VDD_DEF = 32'd1200000;   // T5, ~16.7 ms
    localparam int unsigned T_OFF_MIN_DEF = 32'd36000000;  // T7, 500 ms
    localparam int unsigned FRAME_TMO_DEF = 32'd2400000;   // ~2 frames
    localparam int unsigned DLY_W_DEF     = 32'd26;

    // Backlight PWM prescaler: 72 MHz / (281 * 256) ~ 1 kHz.
    localparam int unsigned PWM_DIV_DEF   = 32'd281;

    // Panel geometry (1366x768, horizontal blanking 50, vertical blanking 12).
    localparam int unsigned H_ACTIVE = 32'd1366;
    localparam int unsigned V_ACTIVE = 32'd768;
    localparam int unsigned H_BLANK  = 32'd50;
    localparam int unsigned V_BLANK  = 32'd12;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_BLANK;

    // Counter preload for a dwell of t cycles; a dwell of 0 behaves as 1.
    function automatic int unsigned dly_load(input int unsigned t);
        return (t == 0) ? 32'd0 : t - 32'd1;
    endfunction

endpackage

// File: rtl/lvds_panel_sequencer_if.sv
// Control/status bundle between the panel sequencer and its host logic.
// bl_duty exists only when LVDS_PANEL_SEQ_BL_PWM_EN is defined.
interface lvds_panel_sequencer_if;
    logic       enable;
    logic       frame_start;
    logic       err_clr;
`ifdef LVDS_PANEL_SEQ_BL_PWM_EN
    logic [7:0] bl_duty;
`endif
    logic       panel_vdd_en;
    logic       video_en;
    logic       bl_en;
    logic       bl_pwm;
    logic       ready;
    logic       frame_err;
    logic [3:0] state_o;

    // Host side: issues requests, observes the panel enables.
    modport master (
        output enable, frame_start, err_clr,
`ifdef LVDS_PANEL_SEQ_BL_PWM_EN
        output bl_duty,
`endif
        input  panel_vdd_en, video_en, bl_en, bl_pwm, ready, frame_err, state_o
    );

    // Sequencer side.
    modport slave (
        input  enable, frame_start, err_clr,
`ifdef LVDS_PANEL_SEQ_BL_PWM_EN
        input  bl_duty,
`endif
        output panel_vdd_en, video_en, bl_en, bl_pwm, ready, frame_err, state_o
    );
endinterface

// File: rtl/lvds_bl_pwm.sv
// Backlight PWM: 8-bit phase stepped every PWM_DIV clocks. Duty is latched
// only at phase wrap so a period is never split between two duty values.
// bl_en_nxt is the sequencer's next-cycle backlight enable, so the
// registered PWM output falls on the same cycle as bl_en.
module lvds_bl_pwm #(
    parameter int unsigned PWM_DIV = 281
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bl_en_nxt,
    input  logic [7:0] bl_duty,
    output logic       bl_pwm
);
    localparam int unsigned DIV_N = (PWM_DIV == 0) ? 1 : PWM_DIV;
    localparam int unsigned DIV_W = (DIV_N < 2) ? 1 : $clog2(DIV_N);

    logic [DIV_W-1:0] div_q;
    logic [7:0]       phase_q;
    logic [7:0]       duty_q;
    logic             step;

    assign step = (div_q == DIV_W'(DIV_N - 1));

    // Prescaler, phase counter, duty latch and registered PWM output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            phase_q <= '0;
            duty_q  <= '0;
            bl_pwm  <= 1'b0;
        end else begin
            if (step) begin
                div_q   <= '0;
                phase_q <= phase_q + 8'd1;
                if (phase_q == 8'hff) duty_q <= bl_duty;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            bl_pwm <= bl_en_nxt & (phase_q < duty_q);
        end
    end
endmodule

// File: rtl/lvds_panel_sequencer.sv
// LVDS panel power sequencer (pixel clock domain). Orders VDD, video and
// backlight per the panel T2..T7 timing and aligns video on/off to frame
// boundaries. Optional backlight PWM: define LVDS_PANEL_SEQ_BL_PWM_EN.
module lvds_panel_sequencer
    import lvds_pkg::*;
#(
    parameter int unsigned T_VDD_VID = T_VDD_VID_DEF,
    parameter int unsigned T_VID_BL  = T_VID_BL_DEF,
    parameter int unsigned T_BL_VID  = T_BL_VID_DEF,
    parameter int unsigned T_VID_VDD = T_VID_VDD_DEF,
    parameter int unsigned T_OFF_MIN = T_OFF_MIN_DEF,
    parameter int unsigned FRAME_TMO = FRAME_TMO_DEF,
    parameter int unsigned DLY_W     = DLY_W_DEF
`ifdef LVDS_PANEL_SEQ_BL_PWM_EN
    ,
    parameter int unsigned PWM_DIV   = PWM_DIV_DEF
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lvds_panel_sequencer_if.slave  bus
);
    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    seq_state_e       state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             dly_done;
    logic             tmo_set;
    logic             vdd_q, video_q, bl_q, frame_err_q;

    // Dwell preload for the state being entered.
    function automatic logic [DLY_W-1:0] load_for(input seq_state_e s);
        int unsigned t;
        case (s)
            ST_VDD_UP:     t = T_VDD_VID;
            ST_VID_ARM:    t = FRAME_TMO;
            ST_VID_UP:     t = T_VID_BL;
            ST_BL_DOWN:    t = T_BL_VID;
            ST_VID_DISARM: t = FRAME_TMO;
            ST_VID_DOWN:   t = T_VID_VDD;
            ST_COOL:       t = T_OFF_MIN;
            default:       t = 32'd1;
        endcase
        return DLY_W'(dly_load(t));
    endfunction

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign dly_done = (cnt_q == '0);

    // Next state; a power-off request during power-up still honours T4/T5.
    always_comb begin
        state_d = state_q;
        tmo_set = 1'b0;
        case (state_q)
            ST_OFF:
                if (bus.enable) state_d = ST_VDD_UP;
            ST_VDD_UP:
                if (!bus.enable)   state_d = ST_VID_DOWN;
                else if (dly_done) state_d = ST_VID_ARM;
            ST_VID_ARM:
                if (!bus.enable)          state_d = ST_VID_DOWN;
                else if (bus.frame_start) state_d = ST_VID_UP;
                else if (dly_done) begin
                    state_d = ST_VID_UP;
                    tmo_set = 1'b1;
                end
            ST_VID_UP:
                if (!bus.enable)   state_d = ST_BL_DOWN;
                else if (dly_done) state_d = ST_RUN;
            ST_RUN:
                if (!bus.enable) state_d = ST_BL_DOWN;
            ST_BL_DOWN:
                if (dly_done) state_d = ST_VID_DISARM;
            ST_VID_DISARM:
                if (bus.frame_start) state_d = ST_VID_DOWN;
                else if (dly_done) begin
                    state_d = ST_VID_DOWN;
                    tmo_set = 1'b1;
                end
            ST_VID_DOWN:
                if (dly_done) state_d = ST_COOL;
            ST_COOL:
                if (dly_done) state_d = ST_OFF;
            default:
                state_d = ST_OFF;
        endcase
    end

    // Dwell counter: preload on entry, count down to zero while in a state.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)  cnt_d = load_for(state_d);
        else if (cnt_q != '0)    cnt_d = cnt_q - DLY_W'(1);
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            vdd_q       <= 1'b0;
            video_q     <= 1'b0;
            bl_q        <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vdd_q   <= (state_d inside {ST_VDD_UP, ST_VID_ARM, ST_VID_UP, ST_RUN,
                                        ST_BL_DOWN, ST_VID_DISARM, ST_VID_DOWN});
            video_q <= (state_d inside {ST_VID_UP, ST_RUN, ST_BL_DOWN, ST_VID_DISARM});
            bl_q    <= (state_d == ST_RUN);
            if (tmo_set)          frame_err_q <= 1'b1;
            else if (bus.err_clr) frame_err_q <= 1'b0;
        end
    end

    assign bus.panel_vdd_en = vdd_q;
    assign bus.video_en     = video_q;
    assign bus.bl_en        = bl_q;
    assign bus.ready        = bl_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.state_o      = state_q;

`ifdef LVDS_PANEL_SEQ_BL_PWM_EN
    lvds_bl_pwm #(
        .PWM_DIV (PWM_DIV)
    ) u_bl_pwm (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .bl_en_nxt (state_d == ST_RUN),
        .bl_duty   (bus.bl_duty),
        .bl_pwm    (bus.bl_pwm)
    );
`else
    assign bus.bl_pwm = bl_q;
`endif
endmodule

// File: tb/tb_lvds_panel_sequencer.sv
// Bench for lvds_panel_sequencer (default build, short timing parameters).
// Per-cycle expected output vectors are queued from the datasheet timeline
// when a scenario starts and popped as the DUT reaches each cycle.
module tb_lvds_panel_sequencer;
    localparam logic [3:0] S_OFF = 4'd0, S_VDD_UP = 4'd1, S_VID_ARM = 4'd2,
                           S_VID_UP = 4'd3, S_RUN = 4'd4, S_BL_DOWN = 4'd5,
                           S_VID_DISARM = 4'd6, S_VID_DOWN = 4'd7, S_COOL = 4'd8;

    typedef struct {
        int         cyc;
        logic [9:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    exp_t sb[$];

    lvds_panel_sequencer_if bus ();

    lvds_panel_sequencer #(
        .T_VDD_VID (4),
        .T_VID_BL  (5),
        .T_BL_VID  (3),
        .T_VID_VDD (2),
        .T_OFF_MIN (6),
        .FRAME_TMO (10),
        .DLY_W     (26)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {state, vdd, video, bl, ready, frame_err, bl_pwm}
    function automatic logic [9:0] obs();
        return {bus.state_o, bus.panel_vdd_en, bus.video_en, bus.bl_en,
                bus.ready, bus.frame_err, bus.bl_pwm};
    endfunction

    // Expected outputs for a state, from the datasheet output table.
    function automatic logic [9:0] expv(input logic [3:0] st, input logic fe);
        logic vdd, vid, bl;
        vdd = (st >= S_VDD_UP) && (st <= S_VID_DOWN);
        vid = (st == S_VID_UP) || (st == S_RUN) || (st == S_BL_DOWN) || (st == S_VID_DISARM);
        bl  = (st == S_RUN);
        return {st, vdd, vid, bl, bl, fe, bl};
    endfunction

    task automatic push_span(input int a, input int b, input logic [3:0] st, input logic fe);
        for (int k = a; k <= b; k++) sb.push_back('{cyc: k, v: expv(st, fe)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        bus.enable = 1'b1; bus.frame_start = 1'b1; bus.err_clr = 1'b0;
        rst_n = 1'b0;
        push_span(0, 3, S_OFF, 1'b0);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); nvec++;
                if (obs() !== e.v) begin nerr++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", c, obs(), e.v); end
            end
            tick();
        end
        bus.enable = 1'b0; bus.frame_start = 1'b0;
        rst_n = 1'b1;
        push_span(0, 3, S_OFF, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); nvec++;
                if (obs() !== e.v) begin nerr++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", c, obs(), e.v); end
            end
            tick();
        end
    endtask

    task automatic test_powerup();
        exp_t e;
        push_span(0, 0, S_OFF, 1'b0);
        push_span(1, 4, S_VDD_UP, 1'b0);
        push_span(5, 7, S_VID_ARM, 1'b0);
        push_span(8, 12, S_VID_UP, 1'b0);
        push_span(13, 15, S_RUN, 1'b0);
        for (int c = 0; c < 16; c++) begin
            if (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); nvec++;
                if (obs() !== e.v) begin nerr++; $display("FAIL powerup cyc=%0d got=%b exp=%b", c, obs(), e.v); end
            end
            bus.enable = 1'b1;
            bus.frame_start = (c == 2) || (c == 7);
            tick();
        end
        bus.frame_start = 1'b0;
    endtask

    task automatic test_powerdown();
        exp_t e;
        push_span(0, 0, S_RUN, 1'b0);
        push_span(1, 3, S_BL_DOWN, 1'b0);
        push_span(4, 5, S_VID_DISARM, 1'b0);
        push_span(6, 7, S_VID_DOWN, 1'b0);
        push_span(8, 13, S_COOL, 1'b0);
        push_span(14, 15, S_OFF, 1'b0);
        for (int c = 0; c < 16; c++) begin
            if (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); nvec++;
                if (obs() !== e.v) begin nerr++; $display("FAIL powerdown cyc=%0d got=%b exp=%b", c, obs(), e.v); end
            end
            bus.enable = 1'b0;
            bus.frame_start = (c == 2) || (c == 5);
            tick();
        end
        bus.frame_start = 1'b0;
    endtask

    task automatic test_frame_timeout();
        exp_t e;
        push_span(0, 0, S_OFF, 1'b0);
        push_span(1, 4, S_VDD_UP, 1'b0);
        push_span(5, 14, S_VID_ARM, 1'b0);
        push_span(15, 19, S_VID_UP, 1'b1);
        push_span(20, 20, S_RUN, 1'b1);
        push_span(21, 22, S_BL_DOWN, 1'b1);
        push_span(23, 23, S_BL_DOWN, 1'b0);
        push_span(24, 33, S_VID_DISARM, 1'b0);
        push_span(34, 35, S_VID_DOWN, 1'b1);
        push_span(36, 36, S_COOL, 1'b1);
        push_span(37, 41, S_COOL, 1'b0);
        push_span(42, 43, S_OFF, 1'b0);
        for (int c = 0; c < 44; c++) begin
            if (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); nvec++;
                if (obs() !== e.v) begin nerr++; $display("FAIL frame_timeout cyc=%0d got=%b exp=%b", c, obs(), e.v); end
            end
            bus.enable = (c < 20);
            bus.frame_start = 1'b0;
            bus.err_clr = (c == 22) || (c == 33) || (c == 36);
            tick();
        end
        bus.err_clr = 1'b0;
    endtask

    task automatic test_abort_vid_up();
        exp_t e;
        push_span(0, 0, S_OFF, 1'b0);
        push_span(1, 4, S_VDD_UP, 1'b0);
        push_span(5, 7, S_VID_ARM, 1'b0);
        push_span(8, 9, S_VID_UP, 1'b0);
        push_span(10, 12, S_BL_DOWN, 1'b0);
        push_span(13, 14, S_VID_DISARM, 1'b0);
        push_span(15, 16, S_VID_DOWN, 1'b0);
        push_span(17, 22, S_COOL, 1'b0);
        push_span(23, 24, S_OFF, 1'b0);
        for (int c = 0; c < 25; c++) begin
            if (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); nvec++;
                if (obs() !== e.v) begin nerr++; $display("FAIL abort_vid_up cyc=%0d got=%b exp=%b", c, obs(), e.v); end
            end
            bus.enable = (c < 9);
            bus.frame_start = (c == 7) || (c == 14);
            tick();
        end
        bus.frame_start = 1'b0;
    endtask

    task automatic test_cool_rerequest();
        exp_t e;
        push_span(0, 0, S_OFF, 1'b0);
        push_span(1, 2, S_VDD_UP, 1'b0);
        push_span(3, 4, S_VID_DOWN, 1'b0);
        push_span(5, 10, S_COOL, 1'b0);
        push_span(11, 11, S_OFF, 1'b0);
        push_span(12, 15, S_VDD_UP, 1'b0);
        push_span(16, 17, S_VID_ARM, 1'b0);
        push_span(18, 22, S_VID_UP, 1'b0);
        push_span(23, 24, S_RUN, 1'b0);
        for (int c = 0; c < 25; c++) begin
            if (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); nvec++;
                if (obs() !== e.v) begin nerr++; $display("FAIL cool_rerequest cyc=%0d got=%b exp=%b", c, obs(), e.v); end
            end
            bus.enable = (c < 2) || (c >= 6);
            bus.frame_start = (c == 17);
            tick();
        end
        bus.frame_start = 1'b0;
    endtask

    task automatic test_reset_in_run();
        logic [9:0] o;
        #2;
        rst_n = 1'b0;
        #1;
        o = obs(); nvec++;
        if (o !== 10'b0) begin nerr++; $display("FAIL async_reset_run got=%b exp=%b", o, 10'b0); end
        tick();
        o = obs(); nvec++;
        if (o !== 10'b0) begin nerr++; $display("FAIL async_reset_hold got=%b exp=%b", o, 10'b0); end
        bus.enable = 1'b0;
        rst_n = 1'b1;
        tick(); tick(); tick();
        o = obs(); nvec++;
        if (o !== expv(S_OFF, 1'b0)) begin nerr++; $display("FAIL reset_run_release got=%b exp=%b", o, expv(S_OFF, 1'b0)); end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_powerdown();
        test_frame_timeout();
        test_abort_vid_up();
        test_cool_rerequest();
        test_reset_in_run();
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/lvds_panel_sequencer.md
Name: lvds_panel_sequencer

Overview:
- Power-sequencing controller for the LVDS panel link, clocked by the pixel clock domain (72 MHz DCM CLKFX).
- Orders panel VDD, the video stream (gate for the encoder's DataEnable and serializer outputs) and the backlight per panel datasheet T1..T5.
- Aligns video on/off to frame boundaries reported by the timing counters.
- Enforces a minimum power-off time.

Parameters:
- T_VDD_VID, 1200000: cycles from VDD on to video armed (T2).
- T_VID_BL, 14400000: cycles from video on to backlight on (T3).
- T_BL_VID, 14400000: cycles from backlight off to video disarm (T4).
- T_VID_VDD, 1200000: cycles from video off to VDD off (T5).
- T_OFF_MIN, 36000000: minimum VDD-off dwell before re-power (T7).
- FRAME_TMO, 2400000: max wait for frame_start before forcing video transition.
- DLY_W, 26: delay counter width; every T_* must be < 2**DLY_W.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  async active-low reset
- enable  in  1  level request: 1 = panel on, 0 = panel off
- frame_start  in  1  one-cycle pulse at column 0 / line 0 of the timing counters
- panel_vdd_en  out  1  panel logic supply enable
- video_en  out  1  gates DataEnable and LVDS output drive
- bl_en  out  1  backlight enable
- bl_pwm  out  1  backlight PWM (see Optional Feature)
- ready  out  1  1 only in state RUN
- frame_err  out  1  sticky; set when FRAME_TMO expires
- err_clr  in  1  pulse; clears frame_err
- state_o  out  4  current state encoding, debug

Behaviour:
- Reset (async assert, sync release): state OFF, all outputs 0, frame_err 0, delay counter 0.
- Delay rule: on state entry the counter loads T-1. The state exits the cycle the counter reads 0, so dwell is exactly T cycles. A T of 0 is treated as 1.
- States and transitions:
  - OFF (all outputs 0): enable=1 -> VDD_UP.
  - VDD_UP (vdd=1): after T_VDD_VID -> VID_ARM.
  - VID_ARM (vdd=1): on frame_start -> VID_UP, with video_en=1 registered on the cycle after the pulse. If FRAME_TMO cycles pass with no pulse -> VID_UP and set frame_err.
  - VID_UP (vdd, video): after T_VID_BL -> RUN.
  - RUN (vdd, video, bl, ready): enable=0 -> BL_DOWN. bl_en and ready drop on the same cycle as the state change.
  - BL_DOWN (vdd, video): after T_BL_VID -> VID_DISARM.
  - VID_DISARM (vdd, video): on frame_start or timeout (also sets frame_err) -> VID_DOWN; video_en drops the cycle after the pulse.
  - VID_DOWN (vdd): after T_VID_VDD -> COOL.
  - COOL (all 0): after T_OFF_MIN -> OFF.
- enable=0 during the power-up states:
  - VDD_UP: jump to VID_DOWN. Video was never on, but T5 is still honoured.
  - VID_ARM: jump to VID_DOWN.
  - VID_UP: jump to BL_DOWN. The backlight never turned on, but T4 is still honoured.
- enable=1 during the power-down states (BL_DOWN..COOL): ignored. The sequence completes to OFF, then re-powers if enable is still 1.
- frame_start during a delay state: ignored. Only VID_ARM and VID_DISARM sample it.
- frame_err: set has priority over err_clr when both occur in the same cycle.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: LVDS_PANEL_SEQ_BL_PWM_EN.
- Defined:
  - Adds ports bl_duty in 8 and parameter PWM_DIV (default 281, giving ~1 kHz at 72 MHz with 256 steps).
  - An 8-bit phase counter advances every PWM_DIV cycles.
  - bl_pwm = bl_en & (phase < bl_duty). bl_duty=255 gives at most 255/256 high; bl_duty=0 gives constant 0.
  - bl_duty is sampled at phase wrap only.
  - On bl_en deassert, bl_pwm drops the same cycle.
- Undefined: bl_pwm = bl_en; no extra ports.

Decomposition:
- Shared package lvds_pkg:
  - state encoding constants (OFF=0, VDD_UP=1, VID_ARM=2, VID_UP=3, RUN=4, BL_DOWN=5, VID_DISARM=6, VID_DOWN=7, COOL=8);
  - default timing constants at 72 MHz.
- The panel geometry constants (1366x768, blanking 50/12) also move there for use by the timing generator.
- Sub-module lvds_bl_pwm holds the optional PWM; instantiated only under the macro.

Test Plan (T_VDD_VID=4, T_VID_BL=5, T_BL_VID=3, T_VID_VDD=2, T_OFF_MIN=6, FRAME_TMO=10):
- Power-up: enable=1 at cycle 0, frame_start at cycle 7 -> vdd=1 at cycle 1; VID_ARM at 5; video_en=1 at 8; bl_en=ready=1 at 13.
- Power-down from RUN: enable=0, frame_start 5 cycles later -> bl_en=0 next cycle; video_en=0 the cycle after the pulse; vdd=0 two cycles later; COOL lasts 6 cycles, then OFF.
- Frame timeout: no frame_start in VID_ARM -> video_en=1 after 10 cycles; frame_err=1. frame_err and err_clr pulsed in the same cycle -> frame_err stays 1; err_clr alone -> 0.
- Abort: enable=0 while in VID_UP -> bl_en never rises; BL_DOWN then VID_DISARM; orderly shutdown to OFF.
- Re-request in COOL: enable toggles 0->1 in COOL -> vdd stays 0 until T_OFF_MIN completes, then VDD_UP.
- rst_n asserted in RUN, mid-cycle -> all outputs 0 immediately (asynchronous); state_o=0.
